// File: rtl/sha256_msg_pad64.sv
// sha256_msg_pad64 - streaming SHA-256 message padder.
// Takes 32-bit big-endian message words and emits padded 512-bit blocks as
// eight 64-bit beats: data, 0x80 marker, zero fill, then the 64-bit bit length.
// Optional build macro SHA256_PAD_OVF_EN adds a sticky len_ovf output that
// flags a wrap of the internal bit-length counter.
module sha256_msg_pad64 #(
  parameter int LEN_W = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic        out_blk_last,
  output logic        out_msg_last
`ifdef SHA256_PAD_OVF_EN
  ,
  output logic        len_ovf
`endif
);

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_PAD  = 2'd1,
    S_LEN  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [2:0]         beat_cnt, beat_n, beat_inc;
  logic               half, half_n;
  logic [LEN_W-1:0]   bit_len, bit_len_n, len_inc;
  logic [31:0]        hold_hi, hold_hi_n;
  logic               pend, pend_n;
  logic               load_ok;
  logic               rdy_c;
  logic               accept;
  logic               ld;
  logic [63:0]        ld_data;
  logic               ld_blk;
  logic               ld_msg;

  // Keep the valid bytes of the final word and drop the marker right after them.
  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [1:0] nb);
    case (nb)
      2'd1:    pad_word = {w[31:24], 8'h80, 16'h0000};
      2'd2:    pad_word = {w[31:16], 8'h80, 8'h00};
      2'd3:    pad_word = {w[31:8], 8'h80};
      default: pad_word = w;
    endcase
  endfunction

  // Number of message bits a word contributes to the length counter.
  function automatic logic [LEN_W-1:0] word_bits(input logic last, input logic [1:0] nb);
    if (!last || nb == 2'd0)
      word_bits = LEN_W'(32);
    else
      word_bits = LEN_W'({nb, 3'b000});
  endfunction

  assign load_ok  = !out_valid || out_ready;
  assign beat_inc = beat_cnt + 3'd1;
  assign len_inc  = word_bits(in_last, in_bytes);
  assign ld_blk   = (beat_cnt == 3'd7);

  // A lone final word must be emitted at once, so it also needs the output slot.
  assign rdy_c    = (state == S_DATA) &&
                    (half ? load_ok : (!(in_valid && in_last) || load_ok));
  assign in_ready = RST && rdy_c;
  assign accept   = in_valid && in_ready;

  // Control state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_DATA;
      beat_cnt <= 3'd0;
      half     <= 1'b0;
      bit_len  <= '0;
      hold_hi  <= 32'h0;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_n;
      half     <= half_n;
      bit_len  <= bit_len_n;
      hold_hi  <= hold_hi_n;
      pend     <= pend_n;
    end
  end

  // Next-state and beat assembly; pend marks a marker owed to the next beat.
  always_comb begin
    state_n   = state;
    beat_n    = beat_cnt;
    half_n    = half;
    bit_len_n = bit_len;
    hold_hi_n = hold_hi;
    pend_n    = pend;
    ld        = 1'b0;
    ld_data   = 64'h0;
    ld_msg    = 1'b0;
    case (state)
      S_DATA: begin
        if (accept) begin
          bit_len_n = bit_len + len_inc;
          if (!in_last) begin
            if (!half) begin
              hold_hi_n = in_data;
              half_n    = 1'b1;
            end else begin
              ld      = 1'b1;
              ld_data = {hold_hi, in_data};
              half_n  = 1'b0;
              beat_n  = beat_inc;
            end
          end else begin
            ld     = 1'b1;
            half_n = 1'b0;
            beat_n = beat_inc;
            pend_n = half && (in_bytes == 2'd0);
            if (half)
              ld_data = {hold_hi, pad_word(in_data, in_bytes)};
            else if (in_bytes == 2'd0)
              ld_data = {in_data, 32'h8000_0000};
            else
              ld_data = {pad_word(in_data, in_bytes), 32'h0000_0000};
            state_n = (!pend_n && beat_inc == 3'd7) ? S_LEN : S_PAD;
          end
        end
      end
      S_PAD: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = pend ? 64'h8000_0000_0000_0000 : 64'h0;
          pend_n  = 1'b0;
          beat_n  = beat_inc;
          if (beat_inc == 3'd7)
            state_n = S_LEN;
        end
      end
      S_LEN: begin
        if (load_ok) begin
          ld        = 1'b1;
          ld_data   = 64'(bit_len);
          ld_msg    = 1'b1;
          beat_n    = 3'd0;
          bit_len_n = '0;
          state_n   = S_DATA;
        end
      end
      default: state_n = S_DATA;
    endcase
  end

  // Output register: loads only when empty or being consumed, otherwise holds.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid    <= 1'b0;
      out_data     <= 64'h0;
      out_blk_last <= 1'b0;
      out_msg_last <= 1'b0;
    end else if (load_ok) begin
      out_valid <= ld;
      if (ld) begin
        out_data     <= ld_data;
        out_blk_last <= ld_blk;
        out_msg_last <= ld_msg;
      end
    end
  end

`ifdef SHA256_PAD_OVF_EN
  logic             msg_open;
  logic [LEN_W:0]   len_sum;
  assign len_sum = {1'b0, bit_len} + {1'b0, len_inc};

  // Sticky length-wrap flag, restarted by the first word of each message.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_ovf  <= 1'b0;
      msg_open <= 1'b0;
    end else if (accept) begin
      msg_open <= 1'b1;
      len_ovf  <= (msg_open ? len_ovf : 1'b0) | len_sum[LEN_W];
    end else if (ld && ld_msg) begin
      msg_open <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_pad64.sv
// tb_sha256_msg_pad64 - scoreboard bench for the SHA-256 message padder.
module tb_sha256_msg_pad64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic [1:0]  in_bytes = 2'd0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready = 1'b0;
  logic        out_blk_last;
  logic        out_msg_last;
`ifdef SHA256_PAD_OVF_EN
  logic        len_ovf;
`endif

  sha256_msg_pad64 dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_bytes     (in_bytes),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .out_blk_last (out_blk_last),
    .out_msg_last (out_msg_last)
`ifdef SHA256_PAD_OVF_EN
    ,
    .len_ovf      (len_ovf)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] d;
    logic        blk;
    logic        msg;
  } beat_t;

  beat_t        sb[$];
  byte unsigned mb[$];
  int n_chk = 0;
  int n_fail = 0;
  int beats_in_msg = 0;
  int rdy_mode = 0;
  int stall_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference padding of the byte message in mb, pushed as expected beats.
  task automatic push_expected();
    byte unsigned p[$];
    logic [63:0] bits;
    int nb;
    beat_t b;
    bits = 64'(mb.size()) * 64'd8;
    foreach (mb[i]) p.push_back(mb[i]);
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
    nb = p.size() / 8;
    for (int i = 0; i < nb; i++) begin
      logic [63:0] d;
      d = 64'h0;
      for (int j = 0; j < 8; j++) d = {d[55:0], p[8 * i + j]};
      b.d   = d;
      b.blk = (i % 8 == 7);
      b.msg = (i == nb - 1);
      sb.push_back(b);
    end
  endtask

  // Drive mb as words; bytes past the end of the message carry the fill value.
  task automatic send_msg(input logic [7:0] fill);
    int nw;
    int nacc;
    push_expected();
    nw = (mb.size() + 3) / 4;
    nacc = 0;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word;
      logic        last;
      logic        acc;
      int          t;
      word = 32'h0;
      for (int j = 0; j < 4; j++) begin
        int idx;
        idx = 4 * w + j;
        word = {word[23:0], (idx < mb.size()) ? mb[idx] : fill};
      end
      last     = (w == nw - 1);
      in_valid = 1'b1;
      in_data  = word;
      in_last  = last;
      in_bytes = last ? 2'(mb.size() % 4) : 2'($urandom);
      acc = 1'b0;
      t = 0;
      while (!acc) begin
        @(negedge CLK);
        acc = in_ready;
        if (out_valid && !out_ready && nacc > 0) begin
          if (nacc % 2 == 1)
            check_val("rdy_bp", 64'(in_ready), 64'd0);
          else if (!last)
            check_val("rdy_open", 64'(in_ready), 64'd1);
        end
        @(posedge CLK); #1;
        t++;
        if (!acc && t > 500) begin
          check_val("in_timeout", 64'd1, 64'd0);
          break;
        end
      end
      nacc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge CLK); #1;
      t++;
    end
    check_val("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic fill_rand(input int n);
    mb.delete();
    for (int i = 0; i < n; i++) mb.push_back(8'($urandom));
  endtask

  task automatic load_abc();
    mb.delete();
    mb.push_back(8'h61);
    mb.push_back(8'h62);
    mb.push_back(8'h63);
  endtask

  // Output monitor: pops the scoreboard on each transfer, checks stalled beats hold.
  initial begin
    logic [63:0] pd;
    logic        pb, pm, pst;
    beat_t       e;
    pst = 1'b0;
    pd = 64'h0;
    pb = 1'b0;
    pm = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        pst = 1'b0;
      end else begin
        if (pst) begin
          check_val("hold_data", out_data, pd);
          check_val("hold_flags", {62'h0, out_blk_last, out_msg_last}, {62'h0, pb, pm});
          check_val("hold_vld", 64'(out_valid), 64'd1);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_val("extra_beat", out_data, 64'hDEAD_BEEF_DEAD_BEEF);
          end else begin
            e = sb.pop_front();
            check_val("beat_data", out_data, e.d);
            check_val("beat_flags", {62'h0, out_blk_last, out_msg_last}, {62'h0, e.blk, e.msg});
            beats_in_msg = e.msg ? 0 : beats_in_msg + 1;
          end
        end
        pst = out_valid && !out_ready;
        pd  = out_data;
        pb  = out_blk_last;
        pm  = out_msg_last;
      end
    end
  end

  // Consumer ready pattern: always, random, or a 3-cycle stall on beat 3.
  initial begin
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(3) != 0);
        default: begin
          if (out_valid && beats_in_msg == 3 && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_vld", 64'(out_valid), 64'd0);
    check_val("rst_data", out_data, 64'h0);
    check_val("rst_flags", {62'h0, out_blk_last, out_msg_last}, 64'h0);
    check_val("rst_rdy", 64'(in_ready), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    check_val("idle_rdy", 64'(in_ready), 64'd1);
    check_val("idle_vld", 64'(out_valid), 64'd0);
    @(posedge CLK); #1;

    rdy_mode = 0;
    load_abc();
    send_msg(8'h00);
    wait_drain();

    fill_rand(55);
    mb[52] = 8'h41;
    mb[53] = 8'h42;
    mb[54] = 8'h43;
    send_msg(8'hA5);
    wait_drain();

    fill_rand(56);
    send_msg(8'hA5);
    wait_drain();

    fill_rand(12);
    send_msg(8'hA5);
    wait_drain();

    rdy_mode = 2;
    stall_cnt = 0;
    fill_rand(48);
    send_msg(8'h5A);
    wait_drain();
    check_val("stall_seen", 64'(stall_cnt), 64'd3);

    rdy_mode = 1;
    for (int m = 0; m < 8; m++) begin
      fill_rand($urandom_range(1, 140));
      send_msg(8'($urandom));
    end
    wait_drain();

    rdy_mode = 0;
    load_abc();
    send_msg(8'h00);
    t = 0;
    while (beats_in_msg < 4 && t < 100) begin
      @(negedge CLK); #2;
      t++;
    end
    check_val("reach_beat4", 64'(beats_in_msg >= 4), 64'd1);
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    check_val("mid_rst_vld", 64'(out_valid), 64'd0);
    check_val("mid_rst_data", out_data, 64'h0);
    check_val("mid_rst_flags", {62'h0, out_blk_last, out_msg_last}, 64'h0);
    check_val("mid_rst_rdy", 64'(in_ready), 64'd0);
    sb.delete();
    beats_in_msg = 0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    load_abc();
    send_msg(8'h00);
    wait_drain();

    repeat (4) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
